snake_frame_tap: RTL
====================

Name: snake_frame_tap

Overview:
- Parametrised, frame-synchronous tap on the processor's wide game-state bus (the snake_data bus).
- Extracts NUM_CH fixed-position fields and waits until they stop changing, so that a half-written multi-instruction update is never captured.
- Publishes the stable fields to the VGA renderer only on a vertical-sync edge, so the display never tears mid-frame.
- Generalises the fixed stage/head1Position/head1 slices to N channels with settle filtering, double buffering and frame accounting.

Parameters:
- DATA_W, 488: width of data_in.
- FIELD_W, 32: width of each channel.
- NUM_CH, 3: number of channels.
- OFF_W, 10: width of each entry in CH_LSB.
- CH_LSB, {10'd360,10'd328,10'd200}: packed LSB bit offsets, channel 0 in the lowest slot. Each offset + FIELD_W must be <= DATA_W; a violation is an elaboration error.
- STABLE_CYCLES, 4: consecutive unchanged cycles required before commit. Must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  game-state bus from the processor; synchronous to clock.
- vsync_in  in  1  VGA vertical sync; asynchronous to clock, active-high.
- ch_out  out  NUM_CH*FIELD_W  published fields, channel 0 at the LSBs.
- frame_update  out  1  one-cycle pulse when ch_out loads new content.
- frame_tick  out  1  one-cycle pulse on every detected vsync rising edge.
- update_count  out  16  number of frame_update pulses since reset; wraps 0xFFFF->0.
- settling  out  1  high while the settle filter is in SETTLING.

Behaviour:
- cur (combinational): concatenation of data_in[CH_LSB[i]+:FIELD_W] for i = 0..NUM_CH-1.
- Reset (async): samp, shadow, ch_out, update_count, cnt = 0; dirty = 0; sync flops = 0; state = STABLE; all pulses = 0.
- Settle FSM, evaluated every clock edge:
  - Any state, cur != samp: samp <= cur, cnt <= 0, state <= SETTLING.
  - SETTLING, cur == samp, cnt == STABLE_CYCLES-1: shadow <= samp, dirty <= 1, state <= STABLE.
  - SETTLING, cur == samp, otherwise: cnt <= cnt+1.
  - STABLE, cur == samp: hold.
  - cnt is $clog2(STABLE_CYCLES+1) bits wide.
- Settle timing:
  - If cur first differs at edge t and then holds, commit occurs at edge t+STABLE_CYCLES.
  - A change during SETTLING restarts the count. Continuous toggling never commits.
- vsync path:
  - Flops s1 <= vsync_in, s2 <= s1, s3 <= s2. Edge detect rise = s2 & ~s3.
  - vsync_in first sampled high at edge n: rise is high during the cycle after edge n+1. Its action occurs at edge n+2.
- On rise, always: frame_tick = 1 for that one cycle.
- On rise with dirty = 1:
  - ch_out <= shadow; dirty <= 0.
  - frame_update = 1 for the following cycle.
  - update_count <= update_count+1.
- On rise with dirty = 0: ch_out, dirty and update_count hold; frame_update stays 0.
- Same edge carries both a commit and a rise:
  - ch_out takes the pre-commit shadow.
  - dirty ends at 1, because the commit wins, so the new data publishes on the next rise.
  - If dirty was 0 before that edge, ch_out reloads the unchanged shadow. No frame_update pulse is produced and update_count does not increment.
- Reset asserted mid-settle or mid-frame: everything is cleared immediately; no partial publish.
- vsync held high: only one rise; next rise requires s2 to go low first.
- settling = (state == SETTLING), registered.

Optional Feature:
- Macro: SNAKE_FRAME_TAP_FREEZE_EN.
- When defined, adds input port freeze (1 bit).
  - While freeze = 1, rise events still pulse frame_tick.
  - ch_out, dirty, frame_update and update_count hold.
  - The settle FSM keeps running, so shadow stays current.
  - On release, the next rise publishes if dirty.
- When undefined: no freeze port; behaviour as above.

Test Plan:
- Reset check: assert reset mid-run -> ch_out = 0, update_count = 0, settling = 0, frame_update = 0 immediately; the async clear takes effect without a clock edge.
- Basic publish: data_in[231:200] = 32'h0000_0105 at edge t, held; vsync rise after edge t+4 -> ch_out[31:0] = 32'h105 at rise edge n+2, frame_update one-cycle pulse, update_count = 1.
- Settle restart: STABLE_CYCLES = 4; field toggles 1,2,3 on consecutive edges then holds 3 -> commit exactly 4 edges after the last change. A vsync before that commit gives frame_tick only; ch_out unchanged.
- No-change frames: three vsync rises with no data change -> three frame_tick pulses, zero frame_update pulses, update_count unchanged.
- Coincident commit and rise: align commit with the rise edge, dirty previously 0 -> ch_out keeps old value, no frame_update; the next rise publishes the new value and update_count increments once.
- Wrap and freeze: preload update_count = 0xFFFF via 65535 publishes (or force), publish -> 0x0000. With SNAKE_FRAME_TAP_FREEZE_EN and freeze = 1, a changed field plus a rise -> ch_out holds; after freeze = 0, the next rise publishes.

Source files
------------

// File: rtl/snake_frame_tap.sv
// snake_frame_tap: settle-filtered tap on the snake_data bus, published to the VGA side on a vsync rise.
// Defining SNAKE_FRAME_TAP_FREEZE_EN adds a freeze input that holds the published side.
module snake_frame_tap #(
    parameter int                        DATA_W        = 488,
    parameter int                        FIELD_W       = 32,
    parameter int                        NUM_CH        = 3,
    parameter int                        OFF_W         = 10,
    parameter logic [NUM_CH*OFF_W-1:0]   CH_LSB        = {10'd360, 10'd328, 10'd200},
    parameter int                        STABLE_CYCLES = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         vsync_in,
`ifdef SNAKE_FRAME_TAP_FREEZE_EN
    input  logic                         freeze,
`endif
    output logic [NUM_CH*FIELD_W-1:0]    ch_out,
    output logic                         frame_update,
    output logic                         frame_tick,
    output logic [15:0]                  update_count,
    output logic                         settling
);

    localparam int               CH_W     = NUM_CH * FIELD_W;
    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_SETTLING = 1'b1;

    logic [CH_W-1:0]  cur;
    logic [CH_W-1:0]  samp;
    logic [CH_W-1:0]  shadow;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic             dirty;
    logic             commit;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             publish;

    // Bad channel placement or a zero settle length must stop elaboration.
    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("snake_frame_tap: STABLE_CYCLES must be at least 1");
        end
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            localparam int LSB = int'(CH_LSB[i*OFF_W +: OFF_W]);
            if (LSB + FIELD_W > DATA_W) begin : g_bad_lsb
                $error("snake_frame_tap: channel field exceeds DATA_W");
            end else begin : g_tap
                assign cur[i*FIELD_W +: FIELD_W] = data_in[LSB +: FIELD_W];
            end
        end
    endgenerate

    // vsync_in is asynchronous: two flops to resynchronise, a third for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= vsync_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    assign frame_tick = rise;

`ifdef SNAKE_FRAME_TAP_FREEZE_EN
    assign publish = rise & ~freeze;
`else
    assign publish = rise;
`endif

    assign commit   = (state == ST_SETTLING) && (cur == samp) && (cnt == CNT_LAST);
    assign settling = (state == ST_SETTLING);

    // Settle filter: any change restarts the count; only a full quiet run reaches shadow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp   <= '0;
            shadow <= '0;
            cnt    <= '0;
            state  <= ST_STABLE;
        end else if (cur != samp) begin
            samp  <= cur;
            cnt   <= '0;
            state <= ST_SETTLING;
        end else if (state == ST_SETTLING) begin
            if (commit) begin
                shadow <= samp;
                state  <= ST_STABLE;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A commit landing on the same edge as a publish keeps dirty set, so it goes out next frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_out       <= '0;
            dirty        <= 1'b0;
            frame_update <= 1'b0;
            update_count <= '0;
        end else begin
            if (commit) begin
                dirty <= 1'b1;
            end else if (publish) begin
                dirty <= 1'b0;
            end
            if (publish) begin
                ch_out <= shadow;
            end
            frame_update <= publish & dirty;
            if (publish && dirty) begin
                update_count <= update_count + 16'd1;
            end
        end
    end

endmodule
